mux_rr_nx1: RTL and testbench
=============================

MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 SHALL have parameter SEL_W, default 2, channel-select width; channel count N_CH = 2**SEL_W.
REQ-002 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_data, input, N_CH*WIDTH, flat channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid, input, N_CH, per-channel valid.
REQ-007 SHALL have port in_ready, output, N_CH, per-channel accept strobe.
REQ-008 SHALL have port sel, input, SEL_W, fixed-mode channel select.
REQ-009 SHALL have port mode, input, 1, 0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-011 SHALL have port out_ch, output, SEL_W, index of the channel that produced out_data.
REQ-012 SHALL have port out_valid, output, 1, out_data/out_ch hold a beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 SHALL define load_en = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-015 Mode 0 SHALL grant channel sel only if in_valid[sel] = 1; otherwise there is no grant, even if other channels are valid.
REQ-016 Mode 1 SHALL grant the first valid channel found searching ptr+1, ptr+2, ... modulo N_CH, where ptr is the last granted channel; ptr = N_CH-1 wraps the search to channel 0.
REQ-017 SHALL assert in_ready[g] = 1 only when load_en = 1 and channel g is granted; at most one in_ready bit SHALL be high per cycle; in_ready SHALL be 0 when there is no grant.
REQ-018 A transfer SHALL occur on channel g when in_valid[g] and in_ready[g] are both 1; the next edge then loads out_data = channel g data, out_ch = g, out_valid = 1.
REQ-019 When load_en = 1 and there is no grant, the edge SHALL clear out_valid to 0; out_data and out_ch SHALL hold their values.
REQ-020 When load_en = 0 (out_valid = 1, out_ready = 0), out_data, out_ch and out_valid SHALL hold stable regardless of sel, mode or input changes.
REQ-021 ptr SHALL update to g on every transfer in either mode and hold otherwise, so a switch to mode 1 resumes after the last served channel.
REQ-022 Latency SHALL be exactly 1 cycle from transfer to out_valid; with out_ready held at 1, throughput SHALL be one beat per cycle.
REQ-023 Changes to mode or sel SHALL affect only the grant computed in the same cycle; a beat already registered SHALL not be altered.
REQ-024 Round-robin SHALL be starvation-free: with all N_CH channels continuously valid and out_ready = 1, each channel SHALL be served once every N_CH transfers.

Reset
REQ-025 While rst = 1, the block SHALL force asynchronously: out_valid = 0, out_data = 0, out_ch = 0, ptr = N_CH-1; in_ready SHALL be all 0.
REQ-026 Reset asserted mid-operation SHALL discard any held beat; the first transfer after rst deasserts SHALL behave as from power-up.

Verification (SEL_W=2, WIDTH=8)
REQ-027 Fixed mode: mode=0, in_data channels 0..3 = 0x11, 0x22, 0x33, 0x44, all valid, out_ready=1, sel stepping 0,1,2,3 one per cycle -> out_data 0x11, 0x22, 0x33, 0x44 with out_ch 0..3, each one cycle after its sel.
REQ-028 Fixed mode with an invalid selected channel: sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid falls to 0 on the next edge.
REQ-029 Round-robin wrap: mode=1, in_valid=4'b1111, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0,1; with in_valid=4'b1001 -> out_ch alternates 0,3,0,3.
REQ-030 Backpressure: out_valid=1 holding 0x33, out_ready=0 for 3 cycles while sel/data change -> out_data stays 0x33, in_ready=0; out_ready=1 -> the next beat loads on the following edge.
REQ-031 Mode switch: transfers in mode 0 with sel=1, then mode=1 with all channels valid -> first round-robin grant is channel 2.
REQ-032 Async reset: assert rst between clock edges while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately; after release, mode=1 with all channels valid -> first out_ch=0.

Source files
------------

// File: rtl/mux_rr_nx1_if.sv
// mux_rr_nx1_if: channel-side and output-side handshake bundle for mux_rr_nx1
// Ports (signals): in_data/in_valid/in_ready per channel, sel/mode grant controls,
// out_data/out_ch/out_valid/out_ready registered output beat.
// slave = the mux, master = the environment driving it.
interface mux_rr_nx1_if #(
    parameter int SEL_W = 2,
    parameter int WIDTH = 8
);
    localparam int N_CH = 1 << SEL_W;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: registered N:1 channel mux with fixed-select or round-robin grant
// Ports: clk (rising edge), rst (async, active-high),
// bus (slave): per-channel in_data/in_valid/in_ready, sel/mode controls,
// out_data/out_ch/out_valid beat with out_ready backpressure.
module mux_rr_nx1 #(
    parameter int SEL_W = 2,
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    mux_rr_nx1_if.slave bus
);
    localparam int N_CH = 1 << SEL_W;
    logic [SEL_W-1:0] ptr_q, ptr_d, ch_q, ch_d, rr_g, g, idx;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, rr_hit, hit, load_en, xfer;
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = ptr_q;
        idx    = ptr_q;
        // scan farthest-first so the nearest valid channel after ptr wins; k = N_CH lands on ptr itself
        for (int k = N_CH; k >= 1; k--) begin
            idx = ptr_q + SEL_W'(k);
            if (bus.in_valid[idx]) begin
                rr_hit = 1'b1;
                rr_g   = idx;
            end
        end
    end
    assign hit          = bus.mode ? rr_hit : bus.in_valid[bus.sel];
    assign g            = bus.mode ? rr_g : bus.sel;
    assign load_en      = !valid_q || bus.out_ready;
    assign xfer         = hit && load_en && !rst;
    assign bus.in_ready = xfer ? N_CH'(1) << g : '0;
    always_comb begin
        valid_d = load_en ? hit : valid_q;
        data_d  = xfer ? bus.in_data[int'(g)*WIDTH +: WIDTH] : data_q;
        ch_d    = xfer ? g : ch_q;
        ptr_d   = xfer ? g : ptr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '1;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1: directed table, corner sequences and randomized model check for mux_rr_nx1
module tb_mux_rr_nx1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mux_rr_nx1_if #(.SEL_W(2), .WIDTH(8)) bus ();
    mux_rr_nx1 #(.SEL_W(2), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_val;
        logic [1:0] e_ch;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural reference: channel number of the grant, or -1
    function automatic int model_grant(input logic m, input int s, input logic [3:0] v, input int p);
        if (!m) return v[s] ? s : -1;
        for (int k = 1; k <= 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v, input logic o,
                                input logic [3:0] r, input logic ev, input logic [1:0] ec, input logic [7:0] ed);
        vec_t x;
        x.mode = m; x.sel = s; x.vld = v; x.ordy = o;
        x.e_rdy = r; x.e_val = ev; x.e_ch = ec; x.e_data = ed;
        return x;
    endfunction

    initial begin
        int mptr, g;
        logic mval;
        logic [1:0] mch;
        logic [7:0] mdata;
        logic [3:0] erdy;
        logic [31:0] rd;

        tbl[0]  = mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h11);
        tbl[1]  = mk(0, 1, 4'b1111, 1, 4'b0010, 1, 1, 8'h22);
        tbl[2]  = mk(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'h33);
        tbl[3]  = mk(0, 3, 4'b1111, 1, 4'b1000, 1, 3, 8'h44);
        tbl[4]  = mk(0, 2, 4'b1011, 1, 4'b0000, 0, 3, 8'h44);
        tbl[5]  = mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h11);
        tbl[6]  = mk(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'h22);
        tbl[7]  = mk(1, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'h33);
        tbl[8]  = mk(1, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'h44);
        tbl[9]  = mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h11);
        tbl[10] = mk(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'h22);
        tbl[11] = mk(1, 0, 4'b1001, 1, 4'b1000, 1, 3, 8'h44);
        tbl[12] = mk(1, 0, 4'b1001, 1, 4'b0001, 1, 0, 8'h11);
        tbl[13] = mk(1, 0, 4'b1001, 1, 4'b1000, 1, 3, 8'h44);
        tbl[14] = mk(1, 0, 4'b1001, 1, 4'b0001, 1, 0, 8'h11);
        tbl[15] = mk(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'h33);
        tbl[16] = mk(0, 0, 4'b1111, 0, 4'b0000, 1, 2, 8'h33);
        tbl[17] = mk(1, 1, 4'b0101, 0, 4'b0000, 1, 2, 8'h33);
        tbl[18] = mk(0, 3, 4'b1111, 0, 4'b0000, 1, 2, 8'h33);
        tbl[19] = mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h11);
        tbl[20] = mk(0, 1, 4'b1111, 1, 4'b0010, 1, 1, 8'h22);
        tbl[21] = mk(1, 3, 4'b1111, 1, 4'b0100, 1, 2, 8'h33);

        bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid = '0; bus.sel = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
        #12;
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_data", 32'(bus.out_data), 0);
        chk("reset_ch", 32'(bus.out_ch), 0);
        bus.in_valid = 4'b1111;
        #1;
        chk("reset_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 22; i++) begin
            bus.mode = tbl[i].mode; bus.sel = tbl[i].sel;
            bus.in_valid = tbl[i].vld; bus.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_ch", i), 32'(bus.out_ch), 32'(tbl[i].e_ch));
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
        end

        // backpressure with changing data: held beat must not change
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = {$urandom, $urandom};
            bus.sel = 2'(i);
            #1;
            chk("bp_ready", 32'(bus.in_ready), 0);
            tick();
            chk("bp_data", 32'(bus.out_data), 32'h33);
            chk("bp_ch", 32'(bus.out_ch), 2);
        end
        bus.in_data = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        bus.out_ready = 1'b1; bus.sel = 2'd3;
        tick();
        chk("bp_release_data", 32'(bus.out_data), 32'hA4);

        // async reset between edges discards the held beat
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_data", 32'(bus.out_data), 0);
        chk("arst_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        chk("arst_first_ch", 32'(bus.out_ch), 0);
        chk("arst_first_data", 32'(bus.out_data), 32'h11);

        // randomized run against the reference model
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        mptr = 3; mval = 1'b0; mch = '0; mdata = '0;
        for (int i = 0; i < 400; i++) begin
            bus.mode = 1'($urandom);
            bus.sel = 2'($urandom);
            bus.in_valid = 4'($urandom);
            bus.out_ready = ($urandom_range(3, 0) != 0);
            bus.in_data = {$urandom, $urandom};
            #1;
            g = model_grant(bus.mode, int'(bus.sel), bus.in_valid, mptr);
            erdy = (g >= 0 && (!mval || bus.out_ready)) ? 4'(1 << g) : 4'b0;
            chk("rnd_ready", 32'(bus.in_ready), 32'(erdy));
            if (!mval || bus.out_ready) begin
                if (g >= 0) begin
                    rd = bus.in_data;
                    mdata = rd[g*8 +: 8];
                    mch = 2'(g);
                    mptr = g;
                    mval = 1'b1;
                end else mval = 1'b0;
            end
            tick();
            chk("rnd_valid", 32'(bus.out_valid), 32'(mval));
            if (mval) begin
                chk("rnd_ch", 32'(bus.out_ch), 32'(mch));
                chk("rnd_data", 32'(bus.out_data), 32'(mdata));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
